// File: rtl/road_fighter_pkg.sv
// rtl/road_fighter_pkg.sv - shared types for the Road Fighter game-state controller
package road_fighter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_GRACE = 3'd3,
        S_OVER  = 3'd4
    } fl_state_t;

    typedef enum logic [1:0] {
        HIT_NONE = 2'd0,
        HIT_ONE  = 2'd1,
        HIT_KILL = 2'd2
    } hit_e;

    // Collapse the per-channel hazard reductions into one event; kill dominates.
    function automatic hit_e resolve_hit(input logic kill_any, input logic soft_any);
        if (kill_any) begin
            return HIT_KILL;
        end else if (soft_any) begin
            return HIT_ONE;
        end
        return HIT_NONE;
    endfunction

endpackage

// File: rtl/sat_fuel_counter.sv
// rtl/sat_fuel_counter.sv - fuel register with load, floored decrement and saturating refill
//
// Ports:
//   clk, resetN  clock, asynchronous active-low reset (value returns to FUEL_MAX)
//   load         force value to FUEL_MAX
//   dec          subtract 1, floor at 0
//   add          add REFILL after the decrement, ceiling at FUEL_MAX
//   value        registered fuel level
//   next_zero    value about to be registered is 0 (lets the FSM react in the same cycle)
module sat_fuel_counter
    import road_fighter_pkg::*;
#(
    parameter int unsigned FUEL_W   = 7,
    parameter int unsigned FUEL_MAX = 99,
    parameter int unsigned REFILL   = 20
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              load,
    input  logic              dec,
    input  logic              add,
    output logic [FUEL_W-1:0] value,
    output logic              next_zero
);

    // One extra bit so that the refill sum can exceed FUEL_MAX before clamping.
    localparam int unsigned W = FUEL_W + 1;
    localparam logic [W-1:0] MAX_W    = W'(FUEL_MAX);
    localparam logic [W-1:0] REFILL_W = W'(REFILL);

    logic [W-1:0]      cur;
    logic [W-1:0]      after_dec;
    logic [W-1:0]      after_add;
    logic [W-1:0]      clamped;
    logic [FUEL_W-1:0] value_nxt;

    always_comb begin
        cur       = {1'b0, value};
        after_dec = (dec && (cur != '0)) ? (cur - W'(1)) : cur;
        after_add = add ? (after_dec + REFILL_W) : after_dec;
        clamped   = (after_add > MAX_W) ? MAX_W : after_add;
        value_nxt = load ? FUEL_W'(FUEL_MAX) : clamped[FUEL_W-1:0];
        next_zero = (value_nxt == '0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            value <= FUEL_W'(FUEL_MAX);
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/fuel_life_ctrl.sv
// rtl/fuel_life_ctrl.sv - fuel countdown, hearts, grace window and game-over FSM
//
// Ports:
//   clk, resetN    clock, asynchronous active-low reset
//   startN         start key, active-low level
//   one_sec_pulse  1 Hz single-cycle tick
//   hazard         per-channel collision levels
//   fuel_pickup    single-cycle fuel can pulse
//   fuel, hearts   registered fuel and heart counts
//   running        in S_RUN or S_GRACE
//   grace          in S_GRACE
//   game_over      in S_OVER
//   heart_lost     pulse on each heart decrement event
//   refilled       pulse when a pickup is applied
module fuel_life_ctrl
    import road_fighter_pkg::*;
#(
    parameter int unsigned       FUEL_W     = 7,
    parameter int unsigned       FUEL_MAX   = 99,
    parameter int unsigned       REFILL     = 20,
    parameter int unsigned       HEART_W    = 2,
    parameter int unsigned       HEARTS_MAX = 3,
    parameter int unsigned       GRACE_SECS = 2,
    parameter int unsigned       N_HAZ      = 2,
    parameter logic [N_HAZ-1:0]  KILL_MASK  = 2'b10
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startN,
    input  logic               one_sec_pulse,
    input  logic [N_HAZ-1:0]   hazard,
    input  logic               fuel_pickup,
    output logic [FUEL_W-1:0]  fuel,
    output logic [HEART_W-1:0] hearts,
    output logic               running,
    output logic               grace,
    output logic               game_over,
    output logic               heart_lost,
    output logic               refilled
);

    localparam int unsigned GW = $clog2(GRACE_SECS + 1);
    localparam logic [GW-1:0]      GRACE_END = GW'(GRACE_SECS);
    localparam logic [HEART_W-1:0] H_MAX     = HEART_W'(HEARTS_MAX);
    localparam logic [HEART_W-1:0] H_ONE     = HEART_W'(1);

    fl_state_t          state, state_nxt;
    logic [HEART_W-1:0] hearts_nxt;
    logic [GW-1:0]      grace_cnt, grace_cnt_nxt;
    logic [GW-1:0]      grace_inc;
    logic               heart_lost_nxt;
    logic               refilled_nxt;
    logic               fuel_load, fuel_dec, fuel_add;
    logic               fuel_next_zero;
    hit_e               hit;

    sat_fuel_counter #(
        .FUEL_W   (FUEL_W),
        .FUEL_MAX (FUEL_MAX),
        .REFILL   (REFILL)
    ) u_fuel (
        .clk       (clk),
        .resetN    (resetN),
        .load      (fuel_load),
        .dec       (fuel_dec),
        .add       (fuel_add),
        .value     (fuel),
        .next_zero (fuel_next_zero)
    );

    assign hit = resolve_hit(|(hazard & KILL_MASK), |(hazard & ~KILL_MASK));

    // Grace timer saturates so a hazard held past the window simply delays the exit.
    assign grace_inc = (one_sec_pulse && (grace_cnt < GRACE_END)) ? (grace_cnt + GW'(1)) : grace_cnt;

    always_comb begin
        state_nxt      = state;
        hearts_nxt     = hearts;
        grace_cnt_nxt  = grace_cnt;
        heart_lost_nxt = 1'b0;
        refilled_nxt   = 1'b0;
        fuel_load      = 1'b0;
        fuel_dec       = 1'b0;
        fuel_add       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!startN) begin
                    state_nxt = S_ARM;
                end
            end

            S_ARM: begin
                fuel_load     = 1'b1;
                hearts_nxt    = H_MAX;
                grace_cnt_nxt = '0;
                if (startN) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                fuel_dec     = one_sec_pulse;
                fuel_add     = fuel_pickup;
                refilled_nxt = fuel_pickup;
                unique case (hit)
                    HIT_KILL: begin
                        hearts_nxt     = '0;
                        heart_lost_nxt = 1'b1;
                        state_nxt      = S_OVER;
                    end
                    HIT_ONE: begin
                        hearts_nxt     = hearts - H_ONE;
                        heart_lost_nxt = 1'b1;
                        grace_cnt_nxt  = '0;
                        state_nxt      = (hearts == H_ONE) ? S_OVER : S_GRACE;
                    end
                    default: ;
                endcase
                if (fuel_next_zero) begin
                    state_nxt = S_OVER;
                end
            end

            S_GRACE: begin
                fuel_dec     = one_sec_pulse;
                fuel_add     = fuel_pickup;
                refilled_nxt = fuel_pickup;
                if (hit == HIT_KILL) begin
                    hearts_nxt     = '0;
                    heart_lost_nxt = 1'b1;
                    state_nxt      = S_OVER;
                end else begin
                    grace_cnt_nxt = grace_inc;
                    if ((grace_inc == GRACE_END) && (hazard == '0)) begin
                        grace_cnt_nxt = '0;
                        state_nxt     = S_RUN;
                    end
                end
                if (fuel_next_zero) begin
                    state_nxt = S_OVER;
                end
            end

            S_OVER: begin
                if (!startN) begin
                    state_nxt = S_ARM;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_IDLE;
            hearts     <= H_MAX;
            grace_cnt  <= '0;
            running    <= 1'b0;
            grace      <= 1'b0;
            game_over  <= 1'b0;
            heart_lost <= 1'b0;
            refilled   <= 1'b0;
        end else begin
            state      <= state_nxt;
            hearts     <= hearts_nxt;
            grace_cnt  <= grace_cnt_nxt;
            running    <= (state_nxt == S_RUN) || (state_nxt == S_GRACE);
            grace      <= (state_nxt == S_GRACE);
            game_over  <= (state_nxt == S_OVER);
            heart_lost <= heart_lost_nxt;
            refilled   <= refilled_nxt;
        end
    end

endmodule

// File: tb/tb_fuel_life_ctrl.sv
// tb/tb_fuel_life_ctrl.sv - directed self-checking bench for fuel_life_ctrl
module tb_fuel_life_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startN;
    logic       one_sec_pulse;
    logic [1:0] hazard;
    logic       fuel_pickup;
    logic [6:0] fuel;
    logic [1:0] hearts;
    logic       running;
    logic       grace;
    logic       game_over;
    logic       heart_lost;
    logic       refilled;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fuel_life_ctrl dut (
        .clk           (clk),
        .resetN        (resetN),
        .startN        (startN),
        .one_sec_pulse (one_sec_pulse),
        .hazard        (hazard),
        .fuel_pickup   (fuel_pickup),
        .fuel          (fuel),
        .hearts        (hearts),
        .running       (running),
        .grace         (grace),
        .game_over     (game_over),
        .heart_lost    (heart_lost),
        .refilled      (refilled)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        one_sec_pulse = 1'b1;
        cyc();
        one_sec_pulse = 1'b0;
    endtask

    task automatic new_game();
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        startN = 1'b0;
        cyc();
        cyc();
        startN = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        resetN        = 1'b0;
        startN        = 1'b1;
        one_sec_pulse = 1'b0;
        hazard        = 2'b00;
        fuel_pickup   = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({fuel, hearts, running, grace, game_over, heart_lost, refilled} !== {7'd99, 2'd3, 5'b00000}) begin
            errors++;
            $display("FAIL reset: fuel=%0d hearts=%0d flags=%b%b%b%b%b want fuel=99 hearts=3 flags=00000",
                     fuel, hearts, running, grace, game_over, heart_lost, refilled);
        end
        resetN = 1'b1;
        cyc();
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: running=%b want 0", running);
        end
    endtask

    task automatic test_start();
        startN = 1'b0;
        repeat (3) cyc();
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL arm_not_running: running=%b want 0", running);
        end
        startN = 1'b1;
        cyc();
        checks++;
        if ({running, fuel, hearts} !== {1'b1, 7'd99, 2'd3}) begin
            errors++;
            $display("FAIL start: running=%b fuel=%0d hearts=%0d want 1 99 3", running, fuel, hearts);
        end
    endtask

    task automatic test_fuel_drain();
        one_sec_pulse = 1'b1;
        repeat (98) cyc();
        checks++;
        if ({fuel, running, game_over} !== {7'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL drain_98: fuel=%0d running=%b over=%b want 1 1 0", fuel, running, game_over);
        end
        cyc();
        one_sec_pulse = 1'b0;
        checks++;
        if ({fuel, running, game_over} !== {7'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL drain_99: fuel=%0d running=%b over=%b want 0 0 1", fuel, running, game_over);
        end
        fuel_pickup = 1'b1;
        hazard      = 2'b01;
        cyc();
        fuel_pickup = 1'b0;
        hazard      = 2'b00;
        checks++;
        if ({fuel, hearts, refilled, heart_lost, game_over} !== {7'd0, 2'd3, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL over_frozen: fuel=%0d hearts=%0d refilled=%b lost=%b over=%b want 0 3 0 0 1",
                     fuel, hearts, refilled, heart_lost, game_over);
        end
    endtask

    task automatic test_refill();
        new_game();
        repeat (9) tick();
        checks++;
        if (fuel !== 7'd90) begin
            errors++;
            $display("FAIL fuel_90: fuel=%0d want 90", fuel);
        end
        one_sec_pulse = 1'b1;
        fuel_pickup   = 1'b1;
        cyc();
        one_sec_pulse = 1'b0;
        fuel_pickup   = 1'b0;
        checks++;
        if ({fuel, refilled} !== {7'd99, 1'b1}) begin
            errors++;
            $display("FAIL refill_sat: fuel=%0d refilled=%b want 99 1", fuel, refilled);
        end
        cyc();
        checks++;
        if (refilled !== 1'b0) begin
            errors++;
            $display("FAIL refill_pulse: refilled=%b want 0", refilled);
        end
        repeat (49) tick();
        fuel_pickup = 1'b1;
        cyc();
        fuel_pickup = 1'b0;
        checks++;
        if (fuel !== 7'd70) begin
            errors++;
            $display("FAIL refill_plain: fuel=%0d want 70", fuel);
        end
        repeat (69) tick();
        one_sec_pulse = 1'b1;
        fuel_pickup   = 1'b1;
        cyc();
        one_sec_pulse = 1'b0;
        fuel_pickup   = 1'b0;
        checks++;
        if ({fuel, running, game_over} !== {7'd20, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rescue: fuel=%0d running=%b over=%b want 20 1 0", fuel, running, game_over);
        end
        startN = 1'b0;
        cyc();
        startN = 1'b1;
        cyc();
        checks++;
        if ({fuel, running} !== {7'd20, 1'b1}) begin
            errors++;
            $display("FAIL start_ignored: fuel=%0d running=%b want 20 1", fuel, running);
        end
    endtask

    task automatic test_hit_grace();
        new_game();
        hazard = 2'b01;
        cyc();
        checks++;
        if ({hearts, heart_lost, grace, running} !== {2'd2, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL hit_one: hearts=%0d lost=%b grace=%b running=%b want 2 1 1 1",
                     hearts, heart_lost, grace, running);
        end
        cyc();
        hazard = 2'b00;
        checks++;
        if ({hearts, heart_lost, grace} !== {2'd2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL grace_ignore: hearts=%0d lost=%b grace=%b want 2 0 1", hearts, heart_lost, grace);
        end
        tick();
        checks++;
        if (grace !== 1'b1) begin
            errors++;
            $display("FAIL grace_tick1: grace=%b want 1", grace);
        end
        tick();
        checks++;
        if ({running, grace} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL grace_exit: running=%b grace=%b want 1 0", running, grace);
        end
    endtask

    task automatic test_kill_in_grace();
        hazard = 2'b01;
        cyc();
        hazard = 2'b00;
        checks++;
        if ({hearts, grace} !== {2'd1, 1'b1}) begin
            errors++;
            $display("FAIL second_hit: hearts=%0d grace=%b want 1 1", hearts, grace);
        end
        hazard = 2'b10;
        cyc();
        hazard = 2'b00;
        checks++;
        if ({hearts, game_over, heart_lost, running} !== {2'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL kill_grace: hearts=%0d over=%b lost=%b running=%b want 0 1 1 0",
                     hearts, game_over, heart_lost, running);
        end
        startN = 1'b0;
        cyc();
        startN = 1'b1;
        cyc();
        checks++;
        if ({fuel, hearts, running, game_over} !== {7'd99, 2'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL restart: fuel=%0d hearts=%0d running=%b over=%b want 99 3 1 0",
                     fuel, hearts, running, game_over);
        end
    endtask

    task automatic test_hold_grace();
        hazard = 2'b01;
        cyc();
        repeat (3) tick();
        checks++;
        if ({hearts, grace, heart_lost} !== {2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_grace: hearts=%0d grace=%b lost=%b want 2 1 0", hearts, grace, heart_lost);
        end
        hazard = 2'b00;
        cyc();
        checks++;
        if ({running, grace} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_release: running=%b grace=%b want 1 0", running, grace);
        end
    endtask

    task automatic test_last_heart();
        hazard = 2'b01;
        cyc();
        hazard = 2'b00;
        tick();
        tick();
        checks++;
        if ({hearts, running, grace} !== {2'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL one_left: hearts=%0d running=%b grace=%b want 1 1 0", hearts, running, grace);
        end
        hazard = 2'b11;
        cyc();
        hazard = 2'b00;
        checks++;
        if ({hearts, game_over, heart_lost, grace} !== {2'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL last_heart: hearts=%0d over=%b lost=%b grace=%b want 0 1 1 0",
                     hearts, game_over, heart_lost, grace);
        end
    endtask

    task automatic test_async_reset();
        new_game();
        repeat (5) tick();
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if ({fuel, hearts, running} !== {7'd99, 2'd3, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: fuel=%0d hearts=%0d running=%b want 99 3 0", fuel, hearts, running);
        end
        resetN = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_start();
        test_fuel_drain();
        test_refill();
        test_hit_grace();
        test_kill_in_grace();
        test_hold_grace();
        test_last_heart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
